hv_reg_slv: RTL and testbench

- Register-bank responder that sits at the far end of the reg access arbiter's register port. It accepts one read or write request per cycle.
- Each write's CRC is checked before commit. Writes to the config space are gated by a two-key lock FSM.
- Read data is returned one cycle after the request, with a freshly computed CRC.
- The bank exposes the config registers and lock/error status to the rest of the HV die.

---
 rtl/hv_reg_slv.sv | 229 ++++++++++++++++++++++
 tb/tb_hv_reg_slv.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_reg_slv.sv
// Register-bank responder at the far end of the register access arbiter: CRC-checked
// writes, a two-key lock guarding the config space, and read data returned with a fresh CRC.
module hv_reg_slv #(
    parameter int                 REG_AW    = 7,
    parameter int                 REG_DW    = 8,
    parameter int                 REG_CRC_W = 8,
    parameter int                 CFG_NUM   = 16,
    parameter logic [REG_AW-1:0]  CFG_BASE  = 7'h10,
    parameter logic [REG_DW-1:0]  CHIP_ID   = 8'h5A
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_rac_reg_ren,
    input  logic                        i_rac_reg_wen,
    input  logic [REG_AW-1:0]           i_rac_reg_addr,
    input  logic [REG_DW-1:0]           i_rac_reg_wdata,
    input  logic [REG_CRC_W-1:0]        i_rac_reg_wcrc,
    output logic                        o_reg_rac_wack,
    output logic                        o_reg_rac_rack,
    output logic [REG_DW-1:0]           o_reg_rac_rdata,
    output logic [REG_CRC_W-1:0]        o_reg_rac_rcrc,
    output logic [CFG_NUM*REG_DW-1:0]   o_cfg_regs,
    output logic                        o_unlocked,
    output logic                        o_crc_err
);

    localparam int MSG_W  = 1 + REG_AW + REG_DW;
    localparam int CFG_IW = (CFG_NUM > 1) ? $clog2(CFG_NUM) : 1;
    localparam int ERR_W  = 4;

    localparam logic [REG_CRC_W-1:0] CRC_POLY = REG_CRC_W'(8'h07);
    localparam logic [REG_AW-1:0]    ADDR_ID     = REG_AW'(0);
    localparam logic [REG_AW-1:0]    ADDR_STATUS = REG_AW'(1);
    localparam logic [REG_AW-1:0]    ADDR_LOCK   = REG_AW'(2);
    localparam logic [REG_AW-1:0]    ADDR_ERRCLR = REG_AW'(3);
    localparam logic [REG_AW:0]      CFG_END     = (REG_AW+1)'(CFG_NUM);
    localparam logic [REG_DW-1:0]    KEY1_VAL    = REG_DW'(8'h5A);
    localparam logic [REG_DW-1:0]    KEY2_VAL    = REG_DW'(8'hA5);
    localparam logic [ERR_W-1:0]     ERR_MAX     = '1;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_KEY1,
        ST_UNLOCKED
    } lock_state_e;

    typedef enum logic [2:0] {
        DEC_ID,
        DEC_STATUS,
        DEC_LOCK,
        DEC_ERRCLR,
        DEC_CFG,
        DEC_NONE
    } dec_e;

    // CRC-8, MSB-first, zero init, no reflection or final XOR
    function automatic logic [REG_CRC_W-1:0] crc_calc(input logic [MSG_W-1:0] msg);
        logic [REG_CRC_W-1:0] c;
        logic                 fb;
        c = '0;
        for (int i = MSG_W - 1; i >= 0; i--) begin
            fb = c[REG_CRC_W-1] ^ msg[i];
            c  = {c[REG_CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        return c;
    endfunction

    lock_state_e                          state_q, state_d;
    logic [CFG_NUM-1:0][REG_DW-1:0]       cfg_q, cfg_d;
    logic [ERR_W-1:0]                     err_cnt_q, err_cnt_d;
    logic                                 rej_q, rej_d;
    logic                                 crc_err_q, crc_err_d;
    logic                                 rack_q, rack_d;
    logic [REG_DW-1:0]                    rdata_q, rdata_d;
    logic [REG_CRC_W-1:0]                 rcrc_q, rcrc_d;

    dec_e                                 dec;
    logic [REG_AW:0]                      cfg_off;
    logic [CFG_IW-1:0]                    cfg_idx;
    logic [REG_CRC_W-1:0]                 wr_crc;
    logic                                 good_wr;
    logic                                 bad_wr;
    logic                                 rd_req;
    logic                                 unlocked;
    logic                                 accepted;
    logic [REG_DW-1:0]                    status_val;
    logic [REG_DW-1:0]                    rd_val;

    // NOTE: every combinational output gets a default before any branch, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        dec     = DEC_NONE;
        cfg_off = {1'b0, i_rac_reg_addr} - {1'b0, CFG_BASE};
        if (i_rac_reg_addr == ADDR_ID) begin
            dec = DEC_ID;
        end else if (i_rac_reg_addr == ADDR_STATUS) begin
            dec = DEC_STATUS;
        end else if (i_rac_reg_addr == ADDR_LOCK) begin
            dec = DEC_LOCK;
        end else if (i_rac_reg_addr == ADDR_ERRCLR) begin
            dec = DEC_ERRCLR;
        end else if ((i_rac_reg_addr >= CFG_BASE) && (cfg_off < CFG_END)) begin
            dec = DEC_CFG;
        end
    end

    assign cfg_idx  = cfg_off[CFG_IW-1:0];
    assign wr_crc   = crc_calc({1'b0, i_rac_reg_addr, i_rac_reg_wdata});
    assign good_wr  = i_rac_reg_wen && (wr_crc == i_rac_reg_wcrc);
    assign bad_wr   = i_rac_reg_wen && (wr_crc != i_rac_reg_wcrc);
    assign rd_req   = i_rac_reg_ren && !i_rac_reg_wen;
    assign unlocked = (state_q == ST_UNLOCKED);

    // LOCK and ERRCLR always take effect; config only while unlocked
    assign accepted = good_wr && ((dec == DEC_LOCK) || (dec == DEC_ERRCLR) ||
                                  ((dec == DEC_CFG) && unlocked));

    always_comb begin
        status_val                = '0;
        status_val[ERR_W-1:0]     = err_cnt_q;
        status_val[4]             = unlocked;
        status_val[5]             = rej_q;
    end

    always_comb begin
        rd_val = '0;
        case (dec)
            DEC_ID:     rd_val = CHIP_ID;
            DEC_STATUS: rd_val = status_val;
            DEC_CFG:    rd_val = cfg_q[cfg_idx];
            default:    rd_val = '0;
        endcase
    end

    // Lock FSM: only good writes move it; a broken key sequence falls back to LOCKED
    // and the offending write is handled as if LOCKED
    always_comb begin
        state_d = state_q;
        if (good_wr) begin
            case (state_q)
                ST_LOCKED: begin
                    if ((dec == DEC_LOCK) && (i_rac_reg_wdata == KEY1_VAL)) begin
                        state_d = ST_KEY1;
                    end
                end
                ST_KEY1: begin
                    if ((dec == DEC_LOCK) && (i_rac_reg_wdata == KEY2_VAL)) begin
                        state_d = ST_UNLOCKED;
                    end else if ((dec == DEC_LOCK) && (i_rac_reg_wdata == KEY1_VAL)) begin
                        state_d = ST_KEY1;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_UNLOCKED: begin
                    if (dec == DEC_LOCK) begin
                        state_d = ST_LOCKED;
                    end
                end
                default: state_d = ST_LOCKED;
            endcase
        end
    end

    always_comb begin
        cfg_d     = cfg_q;
        err_cnt_d = err_cnt_q;
        rej_d     = rej_q;
        crc_err_d = bad_wr;
        if (bad_wr) begin
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (good_wr) begin
            rej_d = !accepted;
            if ((dec == DEC_CFG) && unlocked) begin
                cfg_d[cfg_idx] = i_rac_reg_wdata;
            end
            if ((dec == DEC_ERRCLR) && i_rac_reg_wdata[0]) begin
                err_cnt_d = '0;
            end
        end
    end

    always_comb begin
        rack_d  = rd_req;
        rdata_d = rdata_q;
        rcrc_d  = rcrc_q;
        if (rd_req) begin
            rdata_d = rd_val;
            rcrc_d  = crc_calc({1'b0, i_rac_reg_addr, rd_val});
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples its _d value from before the edge regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_LOCKED;
            // NOTE: the config bank is a handful of flops with a defined reset value,
            // so it is cleared with the rest of the state rather than left as RAM.
            cfg_q     <= '0;
            err_cnt_q <= '0;
            rej_q     <= 1'b0;
            crc_err_q <= 1'b0;
            rack_q    <= 1'b0;
            rdata_q   <= '0;
            rcrc_q    <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            err_cnt_q <= err_cnt_d;
            rej_q     <= rej_d;
            crc_err_q <= crc_err_d;
            rack_q    <= rack_d;
            rdata_q   <= rdata_d;
            rcrc_q    <= rcrc_d;
        end
    end

    assign o_reg_rac_wack  = i_rac_reg_wen;
    assign o_reg_rac_rack  = rack_q;
    assign o_reg_rac_rdata = rdata_q;
    assign o_reg_rac_rcrc  = rcrc_q;
    assign o_cfg_regs      = cfg_q;
    assign o_unlocked      = unlocked;
    assign o_crc_err       = crc_err_q;

endmodule

// File: tb/tb_hv_reg_slv.sv
// Scoreboard bench for hv_reg_slv: directed register-map scenarios followed by
// randomized traffic, both checked against a behavioural register-map model.
module tb_hv_reg_slv;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         ren = 1'b0;
    logic         wen = 1'b0;
    logic [6:0]   addr = '0;
    logic [7:0]   wdata = '0;
    logic [7:0]   wcrc = '0;
    logic         o_wack;
    logic         o_rack;
    logic [7:0]   o_rdata;
    logic [7:0]   o_rcrc;
    logic [127:0] o_cfg;
    logic         o_unl;
    logic         o_crc_err;

    int n_checks = 0;
    int n_errors = 0;

    hv_reg_slv dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_rac_reg_ren   (ren),
        .i_rac_reg_wen   (wen),
        .i_rac_reg_addr  (addr),
        .i_rac_reg_wdata (wdata),
        .i_rac_reg_wcrc  (wcrc),
        .o_reg_rac_wack  (o_wack),
        .o_reg_rac_rack  (o_rack),
        .o_reg_rac_rdata (o_rdata),
        .o_reg_rac_rcrc  (o_rcrc),
        .o_cfg_regs      (o_cfg),
        .o_unlocked      (o_unl),
        .o_crc_err       (o_crc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           rack;
        bit           crc_err;
        bit           unl;
        logic [127:0] cfg;
        logic [7:0]   hold_d;
        logic [7:0]   hold_c;
    } st_t;

    typedef struct {
        logic [7:0] d;
        logic [7:0] c;
    } rd_t;

    st_t st_q[$];
    rd_t rd_q[$];

    // Reference model state
    logic [7:0] crc_tbl [256];
    logic [7:0] cfg_m [16];
    int         err_m;
    bit         rej_m;
    int         stage_m;   // 0 locked, 1 first key seen, 2 unlocked
    logic [7:0] hold_d_m;
    logic [7:0] hold_c_m;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-table CRC-8 (poly 0x07) over the two bytes {0,addr} and data
    function automatic logic [7:0] crc_m(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] c;
        c = crc_tbl[{1'b0, a}];
        c = crc_tbl[c ^ d];
        return c;
    endfunction

    function automatic logic [7:0] read_m(input logic [6:0] a);
        int i;
        i = int'(a);
        if (i == 0) return 8'h5A;
        if (i == 1) return {2'b00, rej_m, (stage_m == 2), 4'(err_m)};
        if (i >= 16 && i < 32) return cfg_m[i-16];
        return 8'h00;
    endfunction

    function automatic logic [127:0] pack_cfg();
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = cfg_m[k];
        return v;
    endfunction

    task automatic model_step(input bit r, input bit rd, input bit wr, input logic [6:0] a,
                              input logic [7:0] d, input logic [7:0] c);
        st_t e;
        e.rack    = 1'b0;
        e.crc_err = 1'b0;
        if (r) begin
            for (int k = 0; k < 16; k++) cfg_m[k] = 8'h00;
            err_m = 0; rej_m = 1'b0; stage_m = 0;
            hold_d_m = 8'h00; hold_c_m = 8'h00;
        end else if (wr) begin
            if (crc_m(a, d) != c) begin
                e.crc_err = 1'b1;
                if (err_m < 15) err_m++;
            end else begin
                bit is_lock, is_cfg, ok;
                is_lock = (a == 7'h02);
                is_cfg  = (int'(a) >= 16 && int'(a) < 32);
                ok      = is_lock || (a == 7'h03) || (is_cfg && stage_m == 2);
                if (is_cfg && stage_m == 2) cfg_m[int'(a)-16] = d;
                if (a == 7'h03 && d[0]) err_m = 0;
                rej_m = !ok;
                if (stage_m == 2) begin
                    if (is_lock) stage_m = 0;
                end else if (stage_m == 1 && is_lock && d == 8'hA5) begin
                    stage_m = 2;
                end else if (is_lock && d == 8'h5A) begin
                    stage_m = 1;
                end else begin
                    stage_m = 0;
                end
            end
        end else if (rd) begin
            hold_d_m = read_m(a);
            hold_c_m = crc_m(a, hold_d_m);
            rd_q.push_back('{hold_d_m, hold_c_m});
            e.rack = 1'b1;
        end
        e.unl    = (stage_m == 2);
        e.cfg    = pack_cfg();
        e.hold_d = hold_d_m;
        e.hold_c = hold_c_m;
        st_q.push_back(e);
    endtask

    task automatic do_op(input bit r, input bit rd, input bit wr, input logic [6:0] a,
                         input logic [7:0] d, input logic [7:0] c);
        @(negedge clk);
        i_rst = r; ren = rd; wen = wr; addr = a; wdata = d; wcrc = c;
        #1;
        check("wack", o_wack, wr);
        model_step(r, rd, wr, a, d, c);
    endtask

    task automatic good_wr(input logic [6:0] a, input logic [7:0] d);
        do_op(1'b0, 1'b0, 1'b1, a, d, crc_m(a, d));
    endtask

    // Result of the op just issued is visible one edge later
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected per-cycle view and, on rack, the expected read data
    initial begin
        st_t e;
        rd_t x;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                check("rack", o_rack, e.rack);
                check("crc_err", o_crc_err, e.crc_err);
                check("unlocked", o_unl, e.unl);
                check("cfg_regs", o_cfg, e.cfg);
                if (o_rack === 1'b1) begin
                    if (rd_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rack_unexpected: got rack=1 with no read outstanding at %0t", $time);
                    end else begin
                        x = rd_q.pop_front();
                        check("rdata", o_rdata, x.d);
                        check("rcrc", o_rcrc, x.c);
                    end
                end else begin
                    check("rdata_hold", o_rdata, e.hold_d);
                    check("rcrc_hold", o_rcrc, e.hold_c);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] a;
        logic [7:0] d;
        logic [7:0] c;
        bit         r, rd, wr;
        int         kind, sel;

        for (int b = 0; b < 256; b++) begin
            logic [7:0] t;
            t = 8'(b);
            for (int k = 0; k < 8; k++) t = t[7] ? ((t << 1) ^ 8'h07) : (t << 1);
            crc_tbl[b] = t;
        end

        do_op(1'b1, 1'b0, 1'b0, 7'h00, 8'h00, 8'h00);
        after_edge();
        check("reset_rack", o_rack, 1'b0);
        check("reset_cfg", o_cfg, 128'h0);

        // ID read: rack only on the following cycle
        do_op(1'b0, 1'b1, 1'b0, 7'h00, 8'h00, 8'h00);
        check("id_rack_same_cycle", o_rack, 1'b0);
        after_edge();
        check("id_rdata", o_rdata, 8'h5A);
        check("id_rcrc", o_rcrc, 8'h81);

        // Unlock with the two keys
        do_op(1'b0, 1'b0, 1'b1, 7'h02, 8'h5A, 8'hAB);
        do_op(1'b0, 1'b0, 1'b1, 7'h02, 8'hA5, 8'h58);
        after_edge();
        check("unlock", o_unl, 1'b1);
        do_op(1'b0, 1'b1, 1'b0, 7'h01, 8'h00, 8'h00);
        after_edge();
        check("status_unlocked", o_rdata, 8'h10);

        do_op(1'b0, 1'b0, 1'b1, 7'h10, 8'h3C, 8'hE3);
        after_edge();
        check("cfg0_written", o_cfg[7:0], 8'h3C);

        // Same config write while locked is rejected
        do_op(1'b1, 1'b0, 1'b0, 7'h00, 8'h00, 8'h00);
        do_op(1'b0, 1'b0, 1'b1, 7'h10, 8'h3C, 8'hE3);
        after_edge();
        check("cfg0_locked", o_cfg[7:0], 8'h00);
        do_op(1'b0, 1'b1, 1'b0, 7'h01, 8'h00, 8'h00);
        after_edge();
        check("status_rej", o_rdata[5], 1'b1);

        // Bad CRC writes, saturation and ERRCLR
        do_op(1'b0, 1'b0, 1'b1, 7'h02, 8'h5A, 8'hAC);
        after_edge();
        check("crc_err_pulse", o_crc_err, 1'b1);
        for (int i = 0; i < 16; i++) do_op(1'b0, 1'b0, 1'b1, 7'h02, 8'h5A, 8'hAC);
        do_op(1'b0, 1'b1, 1'b0, 7'h01, 8'h00, 8'h00);
        after_edge();
        check("err_saturated", o_rdata[3:0], 4'hF);
        check("bad_keeps_locked", o_unl, 1'b0);
        good_wr(7'h03, 8'h01);
        do_op(1'b0, 1'b1, 1'b0, 7'h01, 8'h00, 8'h00);
        after_edge();
        check("err_cleared", o_rdata[3:0], 4'h0);

        // Broken key sequence
        do_op(1'b0, 1'b0, 1'b1, 7'h02, 8'h5A, 8'hAB);
        good_wr(7'h10, 8'h77);
        do_op(1'b0, 1'b0, 1'b1, 7'h02, 8'hA5, 8'h58);
        after_edge();
        check("broken_key_locked", o_unl, 1'b0);
        check("broken_key_cfg0", o_cfg[7:0], 8'h00);

        // wen+ren together: no read response
        do_op(1'b0, 1'b1, 1'b1, 7'h00, 8'h11, crc_m(7'h00, 8'h11));
        after_edge();
        check("wen_wins_no_rack", o_rack, 1'b0);

        // Read then reset: state cleared, no rack after the reset edge
        do_op(1'b0, 1'b0, 1'b1, 7'h02, 8'h5A, 8'hAB);
        do_op(1'b0, 1'b0, 1'b1, 7'h02, 8'hA5, 8'h58);
        good_wr(7'h11, 8'hC3);
        do_op(1'b0, 1'b1, 1'b0, 7'h11, 8'h00, 8'h00);
        do_op(1'b1, 1'b0, 1'b0, 7'h00, 8'h00, 8'h00);
        after_edge();
        check("rst_rack", o_rack, 1'b0);
        check("rst_unlocked", o_unl, 1'b0);
        check("rst_cfg", o_cfg, 128'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r    = ($urandom_range(0, 199) == 0);
            kind = $urandom_range(0, 9);
            rd   = (kind >= 4 && kind <= 8);
            wr   = (kind <= 3) || (kind == 8);
            sel  = $urandom_range(0, 5);
            case (sel)
                0:       a = 7'($urandom_range(0, 3));
                1, 2:    a = 7'(16 + $urandom_range(0, 15));
                3:       a = 7'h02;
                4:       a = 7'($urandom_range(0, 127));
                default: a = 7'h03;
            endcase
            if (a == 7'h02) begin
                case ($urandom_range(0, 3))
                    0, 1:    d = 8'h5A;
                    2:       d = 8'hA5;
                    default: d = 8'($urandom_range(0, 255));
                endcase
            end else begin
                d = 8'($urandom_range(0, 255));
            end
            c = crc_m(a, d);
            if ($urandom_range(0, 99) < 15) c = c ^ (8'h01 << $urandom_range(0, 7));
            do_op(r, rd, wr, a, d, c);
        end

        do_op(1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h00);
        do_op(1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h00);
        after_edge();
        after_edge();
        check("reads_drained", rd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
